// File: rtl/dram_lsu.sv
// dram_lsu: load/store front-end for a 32-bit single-port synchronous data RAM.
// Accepts one request at a time, drives the RAM strobes and performs a
// read-modify-write when a store has only some byte enables set.
// The response is registered and held until it is consumed.
// Optional build macro DRAM_LSU_BOUNDS_EN: when defined, a request with
// addr >= DEPTH never reaches the RAM and is answered with rsp_err=1.
module dram_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                dram_ena,
  output logic                dram_rea,
  output logic                dram_wea,
  output logic [ADDR_W-1:0]   dram_addra,
  output logic [DATA_W-1:0]   dram_dia,
  input  logic [DATA_W-1:0]   dram_doa
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RSP
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   merged;
  logic                req_fire;
  logic                req_oob;

  assign req_fire = req_valid && (state == IDLE);

`ifdef DRAM_LSU_BOUNDS_EN
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  logic err_q;

  assign req_oob = ({1'b0, req_addr} >= DEPTH_W);
  assign rsp_err = err_q;

  // Error flag captured at acceptance and held through the response phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (req_fire) begin
      err_q <= req_oob;
    end
  end
`else
  assign req_oob = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; acceptance branches on operation kind and byte enables.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          if (req_oob)                  state_nxt = RSP;
          else if (!req_we)             state_nxt = RD;
          else if (&req_be)             state_nxt = WR;
          else if (req_be == '0)        state_nxt = RSP;
          else                          state_nxt = RD;
        end
      end
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = lat_we ? WR : RSP;
      WR:      state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte merge of store data over the word read back from the RAM.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < BE_W; i++) begin
      merged[8*i +: 8] = lat_be[i] ? lat_data[8*i +: 8] : dram_doa[8*i +: 8];
    end
  end

  // Request latch and response data; the merged word overwrites the store data
  // so the WR state can drive dram_dia straight from the latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_be   <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            lat_we   <= req_we;
            lat_addr <= req_addr;
            lat_data <= req_wdata;
            lat_be   <= req_be;
            rdata_q  <= '0;
          end
        end
        RD_WAIT: begin
          if (lat_we) lat_data <= merged;
          else        rdata_q  <= dram_doa;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RSP);
  assign busy       = (state != IDLE);
  assign rsp_rdata  = rdata_q;

  assign dram_ena   = reset_n && ((state == RD) || (state == WR));
  assign dram_rea   = reset_n && (state == RD);
  assign dram_wea   = reset_n && (state == WR);
  assign dram_addra = lat_addr;
  assign dram_dia   = lat_data;

endmodule

// File: tb/tb_dram_lsu.sv
// tb_dram_lsu: self-checking bench for dram_lsu with a behavioural sync-read RAM.
// Expected responses are queued when a request is driven and popped on response.
// Out-of-range checks follow the DRAM_LSU_BOUNDS_EN build macro.
module tb_dram_lsu;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        dram_ena;
  logic        dram_rea;
  logic        dram_wea;
  logic [10:0] dram_addra;
  logic [31:0] dram_dia;
  logic [31:0] dram_doa;

  dram_lsu #(
    .DATA_W(32),
    .ADDR_W(11),
    .DEPTH (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dram_ena  (dram_ena),
    .dram_rea  (dram_rea),
    .dram_wea  (dram_wea),
    .dram_addra(dram_addra),
    .dram_dia  (dram_dia),
    .dram_doa  (dram_doa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous read, one-cycle latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (dram_ena) begin
      if (dram_wea) mem[dram_addra] <= dram_dia;
      if (dram_rea) dram_doa <= mem[dram_addra];
    end
  end

  // Strobe monitor sampled on the falling edge.
  int          n_rd;
  int          n_wr;
  int          n_ena;
  int          rd_at_wr;
  logic [10:0] last_rd_addr;
  logic [10:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          cyc;
  initial begin
    n_rd = 0; n_wr = 0; n_ena = 0; rd_at_wr = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
  end
  always @(negedge clk) begin
    if (dram_ena) n_ena++;
    if (dram_ena && dram_rea) begin
      n_rd++;
      last_rd_addr = dram_addra;
    end
    if (dram_ena && dram_wea) begin
      n_wr++;
      rd_at_wr     = n_rd;
      last_wr_addr = dram_addra;
      last_wr_data = dram_dia;
    end
  end
  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] shadow [0:63];
  int          total;
  int          bad;
  int          rd0;
  int          wr0;
  int          en0;
  int          lat;

  // Drives one request, queues its expectation and waits for rsp_valid.
  task automatic send(input logic we, input logic [10:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] er, input logic ee,
                      input int elat);
    int n;
    exp_t x;
    x.rdata = er; x.err = ee; x.lat = elat;
    sb.push_back(x);
    rd0 = n_rd; wr0 = n_wr; en0 = n_ena;
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = 11'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", rsp_err); end
    total++; if ({dram_ena, dram_rea, dram_wea} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b required 000", {dram_ena, dram_rea, dram_wea}); end
    total++; if (dram_addra !== 11'h0 || dram_dia !== 32'h0) begin bad++; $display("FAIL reset_latch: addr %h dia %h required 0/0", dram_addra, dram_dia); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_full_store_load();
    send(1'b1, 11'd3, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2);
    shadow[3] = 32'hDEADBEEF;
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL full_store_latency: got %0d required %0d", lat, e.lat); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL full_store_rdata: got %h required %h", rsp_rdata, e.rdata); end
    total++; if (n_wr - wr0 !== 1 || n_rd - rd0 !== 0) begin bad++; $display("FAIL full_store_strobes: wr %0d rd %0d required 1/0", n_wr - wr0, n_rd - rd0); end
    total++; if (last_wr_addr !== 11'd3 || last_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL full_store_word: addr %h data %h required 3/deadbeef", last_wr_addr, last_wr_data); end
    send(1'b0, 11'd3, 32'h0, 4'h0, shadow[3], 1'b0, 3);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL load_latency: got %0d required %0d", lat, e.lat); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL load_rdata: got %h required %h", rsp_rdata, e.rdata); end
    total++; if (n_rd - rd0 !== 1 || last_rd_addr !== 11'd3) begin bad++; $display("FAIL load_strobe: rd %0d addr %h required 1/3", n_rd - rd0, last_rd_addr); end
  endtask

  task automatic test_partial_store();
    send(1'b1, 11'd5, 32'h11223344, 4'hF, 32'h0, 1'b0, 2);
    shadow[5] = 32'h11223344;
    e = sb.pop_front();
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL preload5_rdata: got %h required %h", rsp_rdata, e.rdata); end
    send(1'b1, 11'd5, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0, 4);
    shadow[5] = 32'h11BB33DD;
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL rmw_latency: got %0d required %0d", lat, e.lat); end
    total++; if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1 || rd_at_wr !== rd0 + 1) begin bad++; $display("FAIL rmw_strobes: rd %0d wr %0d rd_before_wr %0d required 1/1/%0d", n_rd - rd0, n_wr - wr0, rd_at_wr, rd0 + 1); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL rmw_rdata: got %h required %h", rsp_rdata, e.rdata); end
    send(1'b0, 11'd5, 32'h0, 4'h0, shadow[5], 1'b0, 3);
    e = sb.pop_front();
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL rmw_readback: got %h required %h", rsp_rdata, e.rdata); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    send(1'b1, 11'd2, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 2);
    shadow[2] = 32'h0BADF00D;
    e = sb.pop_front();
    send(1'b0, 11'd2, 32'h0, 4'h0, shadow[2], 1'b0, 3);
    rsp_ready = 1'b0;
    e = sb.pop_front();
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL bp_rdata: got %h required %h", rsp_rdata, e.rdata); end
    held = rsp_rdata;
    req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_wdata = $urandom;
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold: cycle %0d valid %b rdata %h ready %b required 1/%h/0", c, rsp_valid, rsp_rdata, req_ready, held);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: ready %b valid %b required 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_zero_be();
    send(1'b1, 11'd7, 32'h77777777, 4'hF, 32'h0, 1'b0, 2);
    shadow[7] = 32'h77777777;
    e = sb.pop_front();
    send(1'b1, 11'd7, 32'h12345678, 4'h0, 32'h0, 1'b0, 1);
    e = sb.pop_front();
    total++; if (lat !== e.lat) begin bad++; $display("FAIL zero_be_latency: got %0d required %0d", lat, e.lat); end
    total++; if (n_ena - en0 !== 0) begin bad++; $display("FAIL zero_be_ena: got %0d required 0", n_ena - en0); end
    send(1'b0, 11'd7, 32'h0, 4'h0, shadow[7], 1'b0, 3);
    e = sb.pop_front();
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL zero_be_word: got %h required %h", rsp_rdata, e.rdata); end
  endtask

  task automatic test_reset_midop();
    send(1'b1, 11'd4, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 2);
    shadow[4] = 32'hCAFEF00D;
    e = sb.pop_front();
    @(posedge clk); #1;
    rd0 = n_rd; wr0 = n_wr;
    req_we = 1'b1; req_addr = 11'd4; req_wdata = 32'h99999999; req_be = 4'h3; req_valid = 1'b1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midop_ready: got %b required 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1 || n_rd - rd0 !== 1) begin bad++; $display("FAIL midop_rd_wait: busy %b rd %0d required 1/1", busy, n_rd - rd0); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL midop_state: busy %b valid %b ready %b required 0/0/1", busy, rsp_valid, req_ready); end
    total++; if (dram_ena !== 1'b0 || dram_addra !== 11'h0) begin bad++; $display("FAIL midop_latch: ena %b addr %h required 0/0", dram_ena, dram_addra); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (n_wr - wr0 !== 0) begin bad++; $display("FAIL midop_no_write: got %0d required 0", n_wr - wr0); end
    send(1'b0, 11'd4, 32'h0, 4'h0, shadow[4], 1'b0, 3);
    e = sb.pop_front();
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL midop_word4: got %h required %h", rsp_rdata, e.rdata); end
  endtask

  task automatic test_bounds();
`ifdef DRAM_LSU_BOUNDS_EN
    send(1'b0, 11'h20, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    e = sb.pop_front();
    total++; if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin bad++; $display("FAIL bounds_rsp: err %b rdata %h required %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
    total++; if (lat !== e.lat || n_ena - en0 !== 0) begin bad++; $display("FAIL bounds_no_ram: lat %0d ena %0d required %0d/0", lat, n_ena - en0, e.lat); end
    send(1'b0, 11'd3, 32'h0, 4'h0, shadow[3], 1'b0, 3);
    e = sb.pop_front();
    total++; if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin bad++; $display("FAIL bounds_inrange: err %b rdata %h required %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
`else
    send(1'b1, 11'h20, 32'h5A5A0F0F, 4'hF, 32'h0, 1'b0, 2);
    shadow[32] = 32'h5A5A0F0F;
    e = sb.pop_front();
    send(1'b0, 11'h20, 32'h0, 4'h0, shadow[32], 1'b0, 3);
    e = sb.pop_front();
    total++; if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin bad++; $display("FAIL nobounds_rsp: err %b rdata %h required %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
    total++; if (n_rd - rd0 !== 1 || last_rd_addr !== 11'h20) begin bad++; $display("FAIL nobounds_strobe: rd %0d addr %h required 1/20", n_rd - rd0, last_rd_addr); end
`endif
  endtask

  task automatic test_random_rmw();
    logic [10:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    for (int k = 8; k < 16; k++) begin
      send(1'b1, 11'(k), 32'(k) * 32'h01010101, 4'hF, 32'h0, 1'b0, 2);
      shadow[k] = 32'(k) * 32'h01010101;
      e = sb.pop_front();
    end
    for (int k = 0; k < 10; k++) begin
      a  = 11'($urandom_range(8, 15));
      wd = $urandom;
      be = 4'($urandom_range(1, 14));
      send(1'b1, a, wd, be, 32'h0, 1'b0, 4);
      shadow[a] = merge(shadow[a], wd, be);
      e = sb.pop_front();
      total++; if (lat !== e.lat || rsp_rdata !== e.rdata) begin bad++; $display("FAIL rand_store: lat %0d rdata %h required %0d/%h", lat, rsp_rdata, e.lat, e.rdata); end
      send(1'b0, a, 32'h0, 4'h0, shadow[a], 1'b0, 3);
      e = sb.pop_front();
      total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL rand_load: addr %0d got %h required %h", a, rsp_rdata, e.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    int t_hs [0:2];
    int n;
    @(posedge clk); #1;
    req_we = 1'b0; req_addr = 11'd3; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      t_hs[k] = cyc;
    end
    req_valid = 1'b0;
    total++; if (t_hs[1] - t_hs[0] !== 4) begin bad++; $display("FAIL b2b_gap0: got %0d required 4", t_hs[1] - t_hs[0]); end
    total++; if (t_hs[2] - t_hs[1] !== 4) begin bad++; $display("FAIL b2b_gap1: got %0d required 4", t_hs[2] - t_hs[1]); end
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++; if (rsp_rdata !== shadow[3]) begin bad++; $display("FAIL b2b_rdata: got %h required %h", rsp_rdata, shadow[3]); end
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_backpressure();
    test_zero_be();
    test_reset_midop();
    test_bounds();
    test_random_rmw();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
